genbus_arbiter: RTL

GENBUS_ARBITER -- requirements
Module: genbus_arbiter

---
 rtl/genbus_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/genbus_arbiter.sv
// Round-robin arbiter that multiplexes NMASTERS masters onto one shared bus.
// Supports lock-held grants, slave wait states and a wait-state timeout abort.
module genbus_arbiter #(
  parameter int NMASTERS = 4,
  parameter int DSIZE    = 2,
  parameter int SSIZE    = DSIZE,
  parameter int ASIZE    = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NMASTERS-1:0]         m_req,
  input  logic [NMASTERS-1:0]         m_lock,
  input  logic [NMASTERS*ASIZE-1:0]   m_adr,
  input  logic [NMASTERS*DSIZE*8-1:0] m_mdata,
  input  logic [NMASTERS*SSIZE-1:0]   m_we,
  input  logic [NMASTERS*SSIZE-1:0]   m_re,
  output logic [NMASTERS*DSIZE*8-1:0] m_sdata,
  output logic [NMASTERS-1:0]         m_ws,
  output logic [NMASTERS-1:0]         m_gnt,
  output logic [ASIZE-1:0]            b_adr,
  output logic [DSIZE*8-1:0]          b_mdata,
  output logic [SSIZE-1:0]            b_we,
  output logic [SSIZE-1:0]            b_re,
  input  logic [DSIZE*8-1:0]          b_sdata,
  input  logic                        b_ws,
  output logic                        err,
  output logic [2:0]                  err_id
);

  localparam int DW = DSIZE * 8;
  localparam int IW = (NMASTERS > 2) ? $clog2(NMASTERS) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state, state_nxt;
  logic [NMASTERS-1:0] gnt_nxt;
  logic [IW-1:0]       gidx, gidx_nxt, rr, rr_nxt, win;
  logic [7:0]          wcnt, wcnt_nxt;
  logic                err_nxt;
  logic [2:0]          err_id_nxt;

  logic                sel_req, sel_lock, sel_strb, active;
  logic [ASIZE-1:0]    sel_adr;
  logic [DW-1:0]       sel_mdata;
  logic [SSIZE-1:0]    sel_we, sel_re;
  logic                wait_cyc, tmo, complete;
  logic [IW:0]         pick_idle, pick_rearb;

  // Returns {found, index}: first set bit of req scanning last+1, last+2, ...
  function automatic logic [IW:0] rr_pick(input logic [NMASTERS-1:0] req,
                                          input logic [IW-1:0]       last);
    logic [IW:0]   res;
    logic [IW-1:0] ii;
    res = '0;
    for (int k = NMASTERS; k >= 1; k--) begin
      ii = IW'((int'(last) + k) % NMASTERS);
      if (req[ii]) res = {1'b1, ii};
    end
    return res;
  endfunction

  always_comb begin
    sel_req   = 1'b0;
    sel_lock  = 1'b0;
    sel_adr   = '0;
    sel_mdata = '0;
    sel_we    = '0;
    sel_re    = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (gidx == IW'(i)) begin
        sel_req   = m_req[i];
        sel_lock  = m_lock[i];
        sel_adr   = m_adr[i*ASIZE +: ASIZE];
        sel_mdata = m_mdata[i*DW +: DW];
        sel_we    = m_we[i*SSIZE +: SSIZE];
        sel_re    = m_re[i*SSIZE +: SSIZE];
      end
    end
  end

  assign active   = (state == ACTIVE);
  assign sel_strb = (|sel_we) | (|sel_re);
  // Timeout uses the raw strobes so a simultaneous request drop still aborts with err.
  assign wait_cyc = active && sel_strb && b_ws;
  assign tmo      = wait_cyc && (wcnt == 8'(TIMEOUT - 1));
  assign complete = active && sel_req && sel_strb && !b_ws;

  assign pick_idle  = rr_pick(m_req, rr);
  assign pick_rearb = rr_pick(m_req & ~m_gnt, rr);
  assign win        = pick_rearb[IW] ? pick_rearb[IW-1:0] : gidx;

  always_comb begin
    b_adr   = '0;
    b_mdata = '0;
    b_we    = '0;
    b_re    = '0;
    if (active && sel_req) begin
      b_adr   = sel_adr;
      b_mdata = sel_mdata;
      b_we    = sel_we;
      b_re    = sel_re;
    end
    for (int i = 0; i < NMASTERS; i++) begin
      m_sdata[i*DW +: DW] = (active && m_gnt[i]) ? b_sdata : '0;
      m_ws[i]             = (active && m_gnt[i]) ? b_ws : m_req[i];
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = m_gnt;
    gidx_nxt   = gidx;
    rr_nxt     = rr;
    wcnt_nxt   = wcnt;
    err_nxt    = 1'b0;
    err_id_nxt = err_id;
    case (state)
      IDLE: begin
        if (pick_idle[IW]) begin
          state_nxt = ACTIVE;
          gidx_nxt  = pick_idle[IW-1:0];
          rr_nxt    = pick_idle[IW-1:0];
          gnt_nxt   = NMASTERS'(1) << pick_idle[IW-1:0];
          wcnt_nxt  = '0;
        end
      end
      ACTIVE: begin
        if (tmo) begin
          err_nxt    = 1'b1;
          err_id_nxt = 3'(gidx);
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          wcnt_nxt   = '0;
        end else if (!sel_req) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          wcnt_nxt  = '0;
        end else if (complete) begin
          wcnt_nxt = '0;
          // The current master re-wins only when nobody else is asking.
          if (!sel_lock) begin
            gidx_nxt = win;
            rr_nxt   = win;
            gnt_nxt  = NMASTERS'(1) << win;
          end
        end else if (wait_cyc) begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      m_gnt  <= '0;
      gidx   <= '0;
      rr     <= IW'(NMASTERS - 1);
      wcnt   <= '0;
      err    <= 1'b0;
      err_id <= '0;
    end else begin
      state  <= state_nxt;
      m_gnt  <= gnt_nxt;
      gidx   <= gidx_nxt;
      rr     <= rr_nxt;
      wcnt   <= wcnt_nxt;
      err    <= err_nxt;
      err_id <= err_id_nxt;
    end
  end

endmodule
